// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared widths, depth and FSM state type for the UART TX queue
package uart_pkg;

  localparam int DATA_W        = 8;
  localparam int DEFAULT_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_START,
    WAIT_DONE
  } tx_queue_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - SIZE x DEPTH storage, one write port, registered-address read
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int SIZE  = DATA_W,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [SIZE-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [SIZE-1:0] rdata_o
);

  logic [SIZE-1:0] mem_q [DEPTH];
  logic [AW-1:0]   raddr_q;

  // Storage write; the array itself is never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read address is captured every cycle; data follows the captured address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      raddr_q <= '0;
    end else begin
      raddr_q <= raddr_i;
    end
  end

  assign rdata_o = mem_q[raddr_q];

endmodule

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - host byte FIFO feeding a UART transmitter; UART_TX_QUEUE_LEVEL_EN adds the level port
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int SIZE  = DATA_W,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] wr_data,
  input  logic            wr_en,
  input  logic            ovf_clr,
  output logic            full,
  output logic            empty,
  output logic            overflow,
  output logic [SIZE-1:0] tx_data,
  output logic            tx_rq,
  input  logic            tx_busy
`ifdef UART_TX_QUEUE_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            ovf_q, ovf_d;
  logic            head_vld_q, head_vld_d;
  logic            wr_ok;
  logic            pop;
  logic [SIZE-1:0] rd_data;

  tx_queue_state_t state_q, state_d;
  logic [SIZE-1:0] tx_data_q, tx_data_d;
  logic            tx_rq_q, tx_rq_d;

  uart_fifo_mem #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // Pointer, count, flag and sticky-overflow next state.
  // The read address is registered inside the storage, so the head byte is
  // only trusted one cycle after the read pointer settles (head_vld).
  always_comb begin
    wr_ok      = wr_en && !full_q;
    pop        = (state_q == IDLE) && !empty_q && head_vld_q && !tx_busy;
    wr_ptr_d   = wr_ptr_q + AW'(wr_ok);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CW'(wr_ok) - CW'(pop);
    empty_d    = (count_d == '0);
    full_d     = (count_d == CW'(DEPTH));
    head_vld_d = (count_q != '0) && !pop;
    ovf_d      = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (wr_en && full_q) begin
      ovf_d = 1'b1;
    end
  end

  // FIFO bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      head_vld_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      head_vld_q <= head_vld_d;
    end
  end

  // Handshake FSM next state: one request per byte, then wait for a full busy cycle.
  always_comb begin
    state_d   = state_q;
    tx_rq_d   = 1'b0;
    tx_data_d = tx_data_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          tx_data_d = rd_data;
          tx_rq_d   = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and transmitter-facing registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
      tx_rq_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      tx_rq_q   <= tx_rq_d;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = ovf_q;
  assign tx_data  = tx_data_q;
  assign tx_rq    = tx_rq_q;

`ifdef UART_TX_QUEUE_LEVEL_EN
  assign level = count_q;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - randomized self-checking bench with transmitter/receiver model
module tb_uart_tx_queue;

  localparam int SIZE  = 8;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [SIZE-1:0] wr_data;
  logic            wr_en;
  logic            ovf_clr;
  logic            full;
  logic            empty;
  logic            overflow;
  logic [SIZE-1:0] tx_data;
  logic            tx_rq;
  logic            tx_busy;
`ifdef UART_TX_QUEUE_LEVEL_EN
  logic [2:0]      level;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] fifo_m[$];
  logic       overflow_m = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         rq_cnt = 0;
  int         viol = 0;
  logic       frame_req = 1'b0;
  logic       frame_active = 1'b0;
  logic       hold_busy = 1'b0;
  logic       stab_armed = 1'b0;
  logic [7:0] cur_byte = 8'h00;
  int         tx_len;

  uart_tx_queue #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .ovf_clr  (ovf_clr),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .tx_data  (tx_data),
    .tx_rq    (tx_rq),
    .tx_busy  (tx_busy)
`ifdef UART_TX_QUEUE_LEVEL_EN
    ,
    .level    (level)
`endif
  );

  always #5 clk = ~clk;

  // Receiver-side capture: every request hands one byte to the transmitter.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset !== 1'b1) begin
        stab_armed = 1'b0;
      end else if (tx_rq === 1'b1) begin
        rq_cnt++;
        if (tx_busy !== 1'b0 || frame_active) viol++;
        got_q.push_back(tx_data);
        if (fifo_m.size() == 0) begin
          viol++;
          exp_q.push_back(~tx_data);
        end else begin
          exp_q.push_back(fifo_m.pop_front());
        end
        cur_byte     = tx_data;
        stab_armed   = 1'b1;
        frame_active = 1'b1;
        frame_req    = 1'b1;
      end else if (stab_armed && frame_active && tx_data !== cur_byte) begin
        viol++;
      end
    end
  end

  // Transmitter model: random start delay, random frame length, optional hold.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      if (frame_req) begin
        frame_req = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #3;
        end
        tx_busy = 1'b1;
        tx_len  = int'($urandom_range(2, 6));
        repeat (tx_len) begin
          @(posedge clk);
          #3;
        end
        while (hold_busy) begin
          @(posedge clk);
          #3;
        end
        tx_busy      = 1'b0;
        frame_active = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_write(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    if (fifo_m.size() < DEPTH) fifo_m.push_back(d);
    else overflow_m = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((fifo_m.size() != 0 || frame_active || frame_req || empty !== 1'b1) && n < 3000) begin
      tick();
      n++;
    end
    repeat (3) tick();
    total++;
    if (n >= 3000) begin
      bad++;
      $display("FAIL drain_%s: queue did not drain, model left %0d bytes, empty=%b", name, fifo_m.size(), empty);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    wr_data = 8'h00;
    repeat (3) tick();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty: got %b want 1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full: got %b want 0", full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    total++; if (tx_rq !== 1'b0) begin bad++; $display("FAIL rst_tx_rq: got %b want 0", tx_rq); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
`ifdef UART_TX_QUEUE_LEVEL_EN
    total++; if (level !== 3'd0) begin bad++; $display("FAIL rst_level: got %0d want 0", level); end
`endif
    reset = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single();
    int g0 = got_q.size();
    int r0 = rq_cnt;
    int v0 = viol;
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    fifo_m.push_back(8'hA5);
    @(posedge clk);
    #1;
    total++; if (tx_rq !== 1'b0) begin bad++; $display("FAIL single_lat_e0: tx_rq got %b want 0", tx_rq); end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL single_empty_after_write: got %b want 0", empty); end
    #1;
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    total++; if (tx_rq !== 1'b0) begin bad++; $display("FAIL single_lat_e1: tx_rq got %b want 0", tx_rq); end
    @(posedge clk);
    #1;
    total++; if (tx_rq !== 1'b1) begin bad++; $display("FAIL single_lat_e2: tx_rq got %b want 1", tx_rq); end
    #1;
    drain("single");
    total++; if (rq_cnt - r0 !== 1) begin bad++; $display("FAIL single_rq_count: got %0d want 1", rq_cnt - r0); end
    total++;
    if (got_q.size() <= g0 || got_q[g0] !== 8'hA5) begin
      bad++; $display("FAIL single_rx_byte: got %h want a5", (got_q.size() > g0) ? got_q[g0] : 8'hxx);
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_empty_end: got %b want 1", empty); end
    total++; if (viol !== v0) begin bad++; $display("FAIL single_protocol: %0d violations want 0", viol - v0); end
  endtask

  task automatic test_burst();
    int g0 = got_q.size();
    int r0 = rq_cnt;
    int v0 = viol;
    for (int i = 1; i <= 4; i++) do_write(8'(i));
    drain("burst");
    total++; if (rq_cnt - r0 !== 4) begin bad++; $display("FAIL burst_rq_count: got %0d want 4", rq_cnt - r0); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (got_q.size() <= g0 + k || got_q[g0+k] !== 8'(k + 1)) begin
        bad++; $display("FAIL burst_order_%0d: got %h want %h", k, (got_q.size() > g0 + k) ? got_q[g0+k] : 8'hxx, 8'(k + 1));
      end
    end
    total++; if (viol !== v0) begin bad++; $display("FAIL burst_protocol: %0d violations want 0", viol - v0); end
  endtask

  task automatic test_overflow();
    int g0 = got_q.size();
    int n = 0;
    hold_busy = 1'b1;
    do_write(8'h10);
    while (tx_busy !== 1'b1 && n < 50) begin tick(); n++; end
    total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL ovf_tx_start: tx_busy got %b want 1", tx_busy); end
    for (int i = 0; i < 6; i++) do_write(8'h20 + 8'(i));
    total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full: got %b want 1", full); end
    total++; if (overflow !== overflow_m) begin bad++; $display("FAIL ovf_flag: got %b want %b", overflow, overflow_m); end
`ifdef UART_TX_QUEUE_LEVEL_EN
    total++; if (level !== 3'(fifo_m.size())) begin bad++; $display("FAIL ovf_level: got %0d want %0d", level, fifo_m.size()); end
`endif
    ovf_clr = 1'b1;
    do_write(8'h99);
    ovf_clr = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr    = 1'b0;
    overflow_m = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full_kept: got %b want 1", full); end
    hold_busy = 1'b0;
    drain("overflow");
    total++; if (got_q.size() - g0 !== 5) begin bad++; $display("FAIL ovf_stored: got %0d bytes want 5", got_q.size() - g0); end
    for (int k = g0; k < got_q.size(); k++) begin
      total++;
      if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL ovf_order_%0d: got %h want %h", k - g0, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_simul();
    int g0 = got_q.size();
    logic [7:0] x = 8'($urandom);
    logic [7:0] y = 8'($urandom);
    wr_en   = 1'b1;
    wr_data = x;
    fifo_m.push_back(x);
    @(posedge clk);
    #2;
    wr_en = 1'b0;
    @(posedge clk);
    #2;
    wr_en   = 1'b1;
    wr_data = y;
    fifo_m.push_back(y);
    @(posedge clk);
    #1;
    total++; if (tx_rq !== 1'b1) begin bad++; $display("FAIL simul_pop: tx_rq got %b want 1", tx_rq); end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL simul_empty: got %b want 0", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL simul_full: got %b want 0", full); end
`ifdef UART_TX_QUEUE_LEVEL_EN
    total++; if (level !== 3'd1) begin bad++; $display("FAIL simul_level: got %0d want 1", level); end
`endif
    #1;
    wr_en = 1'b0;
    drain("simul");
    total++;
    if (got_q.size() != g0 + 2 || got_q[g0] !== x || got_q[g0+1] !== y) begin
      bad++; $display("FAIL simul_order: got %0d bytes, want %h then %h", got_q.size() - g0, x, y);
    end
  endtask

  task automatic test_random();
    int   g0 = got_q.size();
    int   v0 = viol;
    logic drop;
    for (int c = 0; c < 400; c++) begin
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_data = 8'($urandom);
      ovf_clr = ($urandom_range(0, 15) == 0);
      drop    = wr_en && (fifo_m.size() >= DEPTH);
      if (wr_en && !drop) fifo_m.push_back(wr_data);
      if (drop) overflow_m = 1'b1;
      else if (ovf_clr) overflow_m = 1'b0;
      tick();
      total++;
      if (overflow !== overflow_m || full !== (fifo_m.size() == DEPTH) || empty !== (fifo_m.size() == 0)) begin
        bad++;
        $display("FAIL rand_flags_c%0d: ovf/full/empty got %b%b%b want %b%b%b", c, overflow, full, empty,
                 overflow_m, fifo_m.size() == DEPTH, fifo_m.size() == 0);
      end
    end
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    drain("random");
    for (int k = g0; k < got_q.size(); k++) begin
      total++;
      if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL rand_order_%0d: got %h want %h", k - g0, got_q[k], exp_q[k]); end
    end
    total++; if (viol !== v0) begin bad++; $display("FAIL rand_protocol: %0d violations want 0", viol - v0); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr    = 1'b0;
    overflow_m = 1'b0;
  endtask

  task automatic test_reset_mid();
    int r0;
    int n = 0;
    hold_busy = 1'b1;
    do_write(8'h31);
    do_write(8'h32);
    do_write(8'h33);
    while (tx_busy !== 1'b1 && n < 50) begin tick(); n++; end
    total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL rmid_tx_start: tx_busy got %b want 1", tx_busy); end
    reset = 1'b0;
    #1;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL rmid_empty: got %b want 1", empty); end
    total++; if (tx_rq !== 1'b0) begin bad++; $display("FAIL rmid_tx_rq: got %b want 0", tx_rq); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL rmid_full: got %b want 0", full); end
    fifo_m.delete();
    overflow_m = 1'b0;
    tick();
    reset = 1'b1;
    r0 = rq_cnt;
    repeat (5) tick();
    total++; if (rq_cnt !== r0) begin bad++; $display("FAIL rmid_no_rq_after_reset: got %0d requests want 0", rq_cnt - r0); end
    do_write(8'h5C);
    repeat (5) tick();
    total++; if (rq_cnt !== r0) begin bad++; $display("FAIL rmid_no_rq_while_busy: got %0d requests want 0", rq_cnt - r0); end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL rmid_queued: empty got %b want 0", empty); end
    hold_busy = 1'b0;
    drain("reset_mid");
    total++; if (rq_cnt - r0 !== 1) begin bad++; $display("FAIL rmid_rq_count: got %0d want 1", rq_cnt - r0); end
    total++;
    if (got_q.size() == 0 || got_q[got_q.size()-1] !== 8'h5C) begin
      bad++; $display("FAIL rmid_new_byte: got %h want 5c", (got_q.size() > 0) ? got_q[got_q.size()-1] : 8'hxx);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_simul();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
